// File: rtl/multi_button_debouncer.sv
// N-channel push-button front end: 2-FF synchroniser, polarity normalisation,
// stability-timer debounce, and press/release/long-press/auto-repeat pulses.
module multi_button_debouncer #(
  parameter int NUM_BTNS          = 5,
  parameter int ACTIVE_LOW        = 0,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter int REPEAT_CYCLES     = 20000000,
  parameter int REPEAT_EN         = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_BTNS-1:0] i_btn,
  output logic [NUM_BTNS-1:0] o_debounced,
  output logic [NUM_BTNS-1:0] o_press,
  output logic [NUM_BTNS-1:0] o_release,
  output logic [NUM_BTNS-1:0] o_long,
  output logic [NUM_BTNS-1:0] o_repeat,
  output logic                o_any_pressed
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic              IDLE_PIN = (ACTIVE_LOW != 0);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    logic              sync0, sync1, norm, stable, accept;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              press_q, release_q, long_q, repeat_q;

    assign norm   = sync1 ^ IDLE_PIN;
    // The mismatch run completes on this edge, so the new level is taken now.
    assign accept = (norm != stable) && (db_cnt == DB_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sync0     <= IDLE_PIN;
        sync1     <= IDLE_PIN;
        stable    <= 1'b0;
        db_cnt    <= '0;
        hold_cnt  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // and the synchroniser really is two stages deep.
        sync0     <= i_btn[i];
        sync1     <= sync0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;

        if (norm == stable) begin
          db_cnt <= '0;
        end else if (accept) begin
          db_cnt    <= '0;
          stable    <= norm;
          press_q   <= norm;
          release_q <= ~norm;
          hold_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end

        // Hold timer saturates at the threshold, so o_long fires once per press.
        if (stable && !accept && hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + 1'b1;
          long_q   <= (hold_cnt == HOLD_PRE);
        end
      end
    end

    if (REPEAT_EN != 0) begin : g_rep
      localparam int               REP_W    = $clog2(REPEAT_CYCLES + 1);
      localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
      logic [REP_W-1:0] rep_cnt;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          rep_cnt  <= '0;
          repeat_q <= 1'b0;
        end else begin
          repeat_q <= 1'b0;
          if (!stable || accept || hold_cnt != HOLD_MAX) begin
            rep_cnt <= '0;
          end else if (rep_cnt == REP_LAST) begin
            rep_cnt  <= '0;
            repeat_q <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
      end
    end else begin : g_no_rep
      assign repeat_q = 1'b0;
    end

    assign o_debounced[i] = stable;
    assign o_press[i]     = press_q;
    assign o_release[i]   = release_q;
    assign o_long[i]      = long_q;
    assign o_repeat[i]    = repeat_q;
  end

  assign o_any_pressed = |o_debounced;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Self-checking bench: two 2-channel instances (active-high and active-low pins)
// compared every cycle against a window/elapsed-time model plus directed literals.
module tb_multi_button_debouncer;
  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

  logic clk, rst;
  logic [N-1:0] btn, btn_al;
  logic [N-1:0] d_deb, d_pr, d_rl, d_lg, d_rp;
  logic [N-1:0] a_deb, a_pr, a_rl, a_lg, a_rp;
  logic         d_any, a_any;

  multi_button_debouncer #(.NUM_BTNS(N), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .o_debounced(d_deb), .o_press(d_pr),
    .o_release(d_rl), .o_long(d_lg), .o_repeat(d_rp), .o_any_pressed(d_any));

  multi_button_debouncer #(.NUM_BTNS(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1)) dut_al (
    .i_clk(clk), .i_rst(rst), .i_btn(btn_al), .o_debounced(a_deb), .o_press(a_pr),
    .o_release(a_rl), .o_long(a_lg), .o_repeat(a_rp), .o_any_pressed(a_any));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: channels 0-1 are dut, 2-3 are dut_al. A level is accepted when the
  // last D normalised samples all disagree with the current stable level; the
  // long/repeat pulses follow from the number of edges since acceptance.
  logic m_s0[4], m_s1[4], m_stb[4], m_pr[4], m_rl[4], m_lg[4], m_rp[4];
  logic win[4][D];
  int   m_pedge[4];

  always @(posedge clk or posedge rst) begin : model
    logic pin, norm, flip;
    int   held, edge_n;
    if (rst) begin
      for (int m = 0; m < 4; m++) begin
        m_s0[m] = (m >= 2); m_s1[m] = (m >= 2);
        m_stb[m] = 0; m_pr[m] = 0; m_rl[m] = 0; m_lg[m] = 0; m_rp[m] = 0;
        m_pedge[m] = 0;
        for (int j = 0; j < D; j++) win[m][j] = 0;
      end
    end else begin
      edge_n = cyc + 1;
      for (int m = 0; m < 4; m++) begin
        if (m < 2) pin = btn[m];
        else       pin = btn_al[m-2];
        norm = m_s1[m] ^ (m >= 2);
        m_s1[m] = m_s0[m];
        m_s0[m] = pin;
        for (int j = D - 1; j > 0; j--) win[m][j] = win[m][j-1];
        win[m][0] = norm;
        flip = 1;
        for (int j = 0; j < D; j++) if (win[m][j] == m_stb[m]) flip = 0;
        m_pr[m] = 0;
        m_rl[m] = 0;
        if (flip) begin
          m_stb[m] = ~m_stb[m];
          if (m_stb[m]) begin m_pr[m] = 1; m_pedge[m] = edge_n; end
          else m_rl[m] = 1;
        end
        held = edge_n - m_pedge[m];
        m_lg[m] = m_stb[m] && !flip && (held == L);
        m_rp[m] = m_stb[m] && (held > L) && ((held - L) % R == 0);
      end
    end
  end

  // Event logs for dut channel 0 and for dut_al presses.
  int q_press[$], q_rel[$], q_long[$], q_rep[$];
  int al_press_n = 0, al_press_cyc = 0;
  logic [N-1:0] al_press_val = '0;

  always @(negedge clk) begin
    check("deb",      d_deb, {m_stb[1], m_stb[0]});
    check("press",    d_pr,  {m_pr[1],  m_pr[0]});
    check("release",  d_rl,  {m_rl[1],  m_rl[0]});
    check("long",     d_lg,  {m_lg[1],  m_lg[0]});
    check("repeat",   d_rp,  {m_rp[1],  m_rp[0]});
    check("any",      d_any, m_stb[1] | m_stb[0]);
    check("al_deb",     a_deb, {m_stb[3], m_stb[2]});
    check("al_press",   a_pr,  {m_pr[3],  m_pr[2]});
    check("al_release", a_rl,  {m_rl[3],  m_rl[2]});
    check("al_long",    a_lg,  {m_lg[3],  m_lg[2]});
    check("al_repeat",  a_rp,  {m_rp[3],  m_rp[2]});
    check("al_any",     a_any, m_stb[3] | m_stb[2]);
    if (d_pr[0]) q_press.push_back(cyc);
    if (d_rl[0]) q_rel.push_back(cyc);
    if (d_lg[0]) q_long.push_back(cyc);
    if (d_rp[0]) q_rep.push_back(cyc);
    if (a_pr != '0) begin
      al_press_n++;
      al_press_cyc = cyc;
      al_press_val = a_pr;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_logs();
    q_press.delete(); q_rel.delete(); q_long.delete(); q_rep.delete();
  endtask

  int c;

  initial begin
    rst = 1'b1; btn = '0; btn_al = '1;
    tick(3);
    rst = 1'b0;
    tick(3);
    check("rst_deb", d_deb, 0);
    check("rst_any", d_any, 0);
    check("rst_al_deb", a_deb, 0);
    check("rst_al_press_n", al_press_n, 0);

    // Clean short press on channel 0, released before the long threshold.
    clear_logs(); c = cyc; btn[0] = 1'b1;
    tick(8);
    check("t1_deb", d_deb, 2'b01);
    check("t1_any", d_any, 1);
    check("t1_press_n", q_press.size(), 1);
    check("t1_press_at", q_press[0], c + 6);
    tick(8); btn[0] = 1'b0;
    tick(10);
    check("t1_release_n", q_rel.size(), 1);
    check("t1_release_at", q_rel[0], c + 22);
    check("t1_long_n", q_long.size(), 0);
    check("t1_repeat_n", q_rep.size(), 0);

    // Bouncy press, then a 3-cycle glitch while held.
    clear_logs(); c = cyc;
    btn[0] = 1'b1; tick(2); btn[0] = 1'b0; tick(2);
    btn[0] = 1'b1; tick(2); btn[0] = 1'b0; tick(2);
    btn[0] = 1'b1; tick(10);
    btn[0] = 1'b0; tick(3);
    btn[0] = 1'b1; tick(4);
    check("t2_press_n", q_press.size(), 1);
    check("t2_press_at", q_press[0], c + 14);
    check("t2_no_release", q_rel.size(), 0);
    check("t2_deb", d_deb, 2'b01);
    btn[0] = 1'b0; tick(10);
    check("t2_release_at", q_rel.size() == 1 ? q_rel[0] : -1, c + 31);

    // Long press with auto-repeat, released between the 4th and 5th repeat.
    clear_logs(); c = cyc; btn[0] = 1'b1;
    tick(56); btn[0] = 1'b0;
    tick(20);
    check("t3_press_at", q_press.size() == 1 ? q_press[0] : -1, c + 6);
    check("t3_long_n", q_long.size(), 1);
    check("t3_long_at", q_long[0], c + 26);
    check("t3_repeat_n", q_rep.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_repeat_at", q_rep[i], c + 34 + 8 * i);
    check("t3_release_at", q_rel.size() == 1 ? q_rel[0] : -1, c + 62);

    // Active-low pins pressed together on both channels.
    c = cyc; btn_al = '0;
    tick(8);
    check("t5_press_n", al_press_n, 1);
    check("t5_press_at", al_press_cyc, c + 6);
    check("t5_press_val", al_press_val, 2'b11);
    check("t5_deb", a_deb, 2'b11);
    btn_al = '1; tick(10);

    // Reset during a hold, deasserted with the pin still pressed.
    clear_logs(); c = cyc; btn[0] = 1'b1;
    tick(21);
    rst = 1'b1;
    #1;
    check("t6_rst_deb", d_deb, 0);
    check("t6_rst_any", d_any, 0);
    check("t6_rst_pulses", d_pr | d_rl | d_lg | d_rp, 0);
    clear_logs();
    tick(2); rst = 1'b0;
    tick(30);
    check("t6_press_at", q_press.size() == 1 ? q_press[0] : -1, c + 29);
    check("t6_long_at", q_long.size() == 1 ? q_long[0] : -1, c + 49);
    check("t6_no_release", q_rel.size(), 0);
    btn[0] = 1'b0; tick(10);
    check("t6_repeat_at", q_rep.size() == 1 ? q_rep[0] : -1, c + 57);
    check("t6_release_at", q_rel.size() == 1 ? q_rel[0] : -1, c + 59);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
